// File: rtl/sram_like_arbiter.sv
// Shares one sram-like memory port between the inst and data masters; one outstanding
// transaction, data-side priority with a saturating starvation counter that forces inst through.
module sram_like_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA
    } state_t;

    state_t             state, state_next;
    logic               owner;
    logic [CNT_W-1:0]   cnt;

    logic               grant;
    logic               win_data;
    logic               sel;
    logic               owner_req;
    logic               addr_hit;
    logic               complete;

    // In IDLE the port follows the combinational winner; afterwards the latched owner.
    always_comb begin
        grant     = inst_req || data_req;
        win_data  = data_req && !(inst_req && (cnt == CNT_W'(STARVE_LIMIT)));
        sel       = (state == S_IDLE) ? win_data : owner;
        owner_req = sel ? data_req : inst_req;

        mem_wr    = sel ? data_wr    : inst_wr;
        mem_size  = sel ? data_size  : inst_size;
        mem_addr  = sel ? data_addr  : inst_addr;
        mem_wdata = sel ? data_wdata : inst_wdata;

        mem_req    = 1'b0;
        complete   = 1'b0;
        state_next = state;
        case (state)
            S_IDLE: begin
                mem_req  = grant;
                complete = grant && mem_addr_ok && mem_data_ok;
                if (grant) begin
                    if (mem_addr_ok && mem_data_ok) state_next = S_IDLE;
                    else if (mem_addr_ok)           state_next = S_DATA;
                    else                            state_next = S_ADDR;
                end
            end
            S_ADDR: begin
                mem_req  = owner_req;
                complete = owner_req && mem_addr_ok && mem_data_ok;
                if (!owner_req)                      state_next = S_IDLE;
                else if (mem_addr_ok && mem_data_ok) state_next = S_IDLE;
                else if (mem_addr_ok)                state_next = S_DATA;
            end
            S_DATA: begin
                complete = mem_data_ok;
                if (mem_data_ok) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase

        if (rst) begin
            mem_req  = 1'b0;
            complete = 1'b0;
        end

        addr_hit     = mem_req && mem_addr_ok;
        inst_addr_ok = addr_hit && !sel;
        data_addr_ok = addr_hit && sel;
        inst_data_ok = complete && !sel;
        data_data_ok = complete && sel;
        inst_rdata   = mem_rdata;
        data_rdata   = mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            owner <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (state == S_IDLE && grant) begin
                owner <= win_data;
                if (win_data && inst_req)
                    cnt <= (cnt == CNT_W'(STARVE_LIMIT)) ? cnt : cnt + CNT_W'(1);
                else
                    cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed vector bench for sram_like_arbiter: a cycle-by-cycle table plus a starvation sequence.
module tb_sram_like_arbiter;

    localparam logic [31:0] IA = 32'hBFC0_0000;
    localparam logic [31:0] DA = 32'h8000_1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    sram_like_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata)
    );

    // ok4 = {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}; exp_addr 0 = don't care
    typedef struct {
        logic        rst;
        logic        ireq;
        logic        dreq;
        logic        aok;
        logic        dok;
        logic [31:0] rdata;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic [3:0]  exp_ok;
    } vec_t;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    task automatic apply(input vec_t v, input string name);
        logic [3:0] ok;
        logic       bad;
        @(negedge clk);
        rst         = v.rst;
        inst_req    = v.ireq;
        data_req    = v.dreq;
        mem_addr_ok = v.aok;
        mem_data_ok = v.dok;
        mem_rdata   = v.rdata;
        #1;
        ok  = {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok};
        bad = (mem_req !== v.exp_req) || (ok !== v.exp_ok)
           || (inst_rdata !== v.rdata) || (data_rdata !== v.rdata)
           || (v.exp_addr != 32'h0 && mem_addr !== v.exp_addr);
        if (v.exp_addr == DA)
            bad = bad || (mem_wr !== 1'b1) || (mem_wdata !== 32'h1111_2222);
        else if (v.exp_addr == IA)
            bad = bad || (mem_wr !== 1'b0) || (mem_wdata !== 32'h0);
        n_vec++;
        if (bad) begin
            n_bad++;
            $display("FAIL %s: got req=%b addr=%h ok=%b rdata=%h/%h, expected req=%b addr=%h ok=%b rdata=%h",
                     name, mem_req, mem_addr, ok, inst_rdata, data_rdata,
                     v.exp_req, v.exp_addr, v.exp_ok, v.rdata);
        end
    endtask

    vec_t tbl[$];
    string nm[$];

    task automatic add(input logic r, input logic i, input logic d, input logic a, input logic k,
                       input logic [31:0] rd, input logic er, input logic [31:0] ea,
                       input logic [3:0] eo, input string name);
        vec_t v;
        v.rst = r; v.ireq = i; v.dreq = d; v.aok = a; v.dok = k; v.rdata = rd;
        v.exp_req = er; v.exp_addr = ea; v.exp_ok = eo;
        tbl.push_back(v);
        nm.push_back(name);
    endtask

    initial begin
        vec_t v;
        logic [6:0] starve_pat;

        rst = 1'b1; inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
        mem_rdata = '0;
        inst_wr = 1'b0; inst_size = 2'd2; inst_addr = IA; inst_wdata = 32'h0;
        data_wr = 1'b1; data_size = 2'd2; data_addr = DA; data_wdata = 32'h1111_2222;

        //   rst i  d  aok dok rdata          req addr ok
        add(1, 1, 1, 1, 1, 32'h0,          0, 0,  4'b0000, "reset0");
        add(1, 1, 1, 1, 1, 32'h0,          0, 0,  4'b0000, "reset1");
        add(0, 0, 0, 0, 0, 32'h0,          0, 0,  4'b0000, "idle_after_reset");
        add(0, 1, 0, 0, 0, 32'h0,          1, IA, 4'b0000, "inst_rd_c0");
        add(0, 1, 0, 1, 0, 32'h0,          1, IA, 4'b1000, "inst_rd_addr_ok");
        add(0, 0, 0, 1, 0, 32'h0,          0, IA, 4'b0000, "inst_rd_data_ignore_aok");
        add(0, 0, 0, 0, 1, 32'h3C1D_0010,  0, IA, 4'b0100, "inst_rd_data_ok");
        add(0, 0, 0, 0, 0, 32'h0,          0, 0,  4'b0000, "idle_gap");
        add(0, 1, 1, 1, 0, 32'h0,          1, DA, 4'b0010, "both_req_data_wins");
        add(0, 1, 0, 0, 1, 32'h5555_AAAA,  0, DA, 4'b0001, "data_done_inst_waits");
        add(0, 1, 0, 1, 1, 32'h0123_4567,  1, IA, 4'b1100, "inst_next_same_cycle");
        add(0, 0, 0, 0, 1, 32'h0,          0, 0,  4'b0000, "stray_data_ok_dropped");
        add(0, 0, 1, 1, 1, 32'h89AB_CDEF,  1, DA, 4'b0011, "data_same_cycle");
        add(0, 1, 0, 0, 0, 32'h0,          1, IA, 4'b0000, "still_idle_inst_grant");
        add(0, 1, 1, 0, 0, 32'h0,          1, IA, 4'b0000, "addr_lock_vs_data");
        add(0, 0, 1, 0, 0, 32'h0,          0, 0,  4'b0000, "inst_withdraw");
        add(0, 0, 1, 1, 0, 32'h0,          1, DA, 4'b0010, "data_after_withdraw");
        add(0, 0, 0, 0, 1, 32'h7777_0000,  0, DA, 4'b0001, "data_after_withdraw_done");
        add(0, 0, 0, 0, 0, 32'h0,          0, 0,  4'b0000, "idle_end");

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], nm[i]);

        // Both held with one-cycle completions: four data grants, one forced inst, then data.
        starve_pat = 7'b1111011;
        for (int i = 0; i < 7; i++) begin
            v.rst = 0; v.ireq = 1; v.dreq = 1; v.aok = 1; v.dok = 1;
            v.rdata = 32'hC0DE_0000 + 32'(i);
            v.exp_req = 1;
            v.exp_addr = starve_pat[6 - i] ? DA : IA;
            v.exp_ok   = starve_pat[6 - i] ? 4'b0011 : 4'b1100;
            apply(v, $sformatf("starve_grant%0d", i));
        end

        // Mid-transaction reset must abort to IDLE with outputs quiet.
        add(0, 1, 0, 0, 0, 32'h0, 1, IA, 4'b0000, "pre_reset_addr");
        add(1, 1, 0, 1, 1, 32'h0, 0, 0,  4'b0000, "reset_in_addr");
        add(0, 0, 1, 1, 0, 32'h0, 1, DA, 4'b0010, "after_reset_idle");
        add(0, 0, 0, 0, 1, 32'h0, 0, DA, 4'b0001, "after_reset_done");
        for (int i = 19; i < tbl.size(); i++) apply(tbl[i], nm[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
